spi_slave_gen: RTL

Parametrised SPI slave front-end for the SPI-RAM subsystem; successor to the fixed 10-bit slave. Deserialises one command/address/data word per frame from `mosi` into `rx_data` for the RAM, serialises one read word from the RAM onto `miso`, and tracks the held read address. Adds configurable payload width, a one-word-per-frame discipline, command/path checking, frame-abort detection and a read-data timeout, all reported on `frame_err`.

---
 rtl/spi_gen_pkg.sv | 34 +++
 rtl/spi_tx_serializer.sv | 55 +++++
 rtl/spi_slave_gen.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/spi_gen_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_gen_pkg
// Description : Shared types, command codes and width helper for the
//               parametrised SPI slave front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package spi_gen_pkg;

   // Frame controller states
   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_CHK_CMD   = 3'd1,
      ST_WRITE     = 3'd2,
      ST_READ_ADD  = 3'd3,
      ST_READ_DATA = 3'd4,
      ST_WAIT_TX   = 3'd5,
      ST_TX        = 3'd6,
      ST_DONE      = 3'd7
   } state_t;

   // Command field carried in the two MSBs of every received word
   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

   // Received word width: command (2 bits) plus payload
   function automatic int rx_w(input int payload_w);
      return payload_w + 2;
   endfunction

endpackage
`default_nettype wire

// File: rtl/spi_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : spi_tx_serializer
// Description : Parallel-load MSB-first shift register. The MSB appears on
//               miso in the cycle after load; done flags the last bit so the
//               controller can leave TX on the following edge, when miso
//               returns to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_tx_serializer #(
   parameter int PAYLOAD_W = 8
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 load,
   input  logic                 clear,
   input  logic [PAYLOAD_W-1:0] data,
   output logic                 miso,
   output logic                 done
);

   localparam int CNT_W = (PAYLOAD_W > 1) ? $clog2(PAYLOAD_W) : 1;
   localparam logic [CNT_W-1:0] C_LAST = CNT_W'(PAYLOAD_W - 1);

   logic [PAYLOAD_W-1:0] r_shreg;
   logic [CNT_W-1:0]     r_cnt;
   logic                 r_active;

   // Load, shift one bit per edge, and go idle after the last bit
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_shreg  <= '0;
         r_cnt    <= '0;
         r_active <= 1'b0;
      end else if (load) begin
         r_shreg  <= data;
         r_cnt    <= '0;
         r_active <= 1'b1;
      end else if (clear) begin
         r_active <= 1'b0;
      end else if (r_active) begin
         if (r_cnt == C_LAST) begin
            r_active <= 1'b0;
         end else begin
            r_shreg <= r_shreg << 1;
            r_cnt   <= r_cnt + 1'b1;
         end
      end
   end

   assign miso = r_active & r_shreg[PAYLOAD_W-1];
   assign done = r_active && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/spi_slave_gen.sv
`default_nettype none
// ============================================================================
// Module      : spi_slave_gen
// Description : SPI slave front-end for the SPI-RAM subsystem. Receives one
//               {cmd, payload} word per frame, checks the command against the
//               path bit, serialises one read word, and reports abort,
//               command mismatch and read-data timeout on frame_err.
// Revision    : 1.0 - initial release
// ============================================================================
module spi_slave_gen
   import spi_gen_pkg::*;
#(
   parameter int PAYLOAD_W  = 8,
   parameter int TX_TIMEOUT = 16
) (
   input  logic                 clk,
   input  logic                 arst,
   input  logic                 ss_n,
   input  logic                 mosi,
   output logic                 miso,
   output logic [PAYLOAD_W+1:0] rx_data,
   output logic                 rx_valid,
   input  logic [PAYLOAD_W-1:0] tx_data,
   input  logic                 tx_valid,
   output logic                 frame_err,
   output logic                 rd_addr_held,
   output logic                 busy
);

   localparam int RX_W = rx_w(PAYLOAD_W);
   localparam int BC_W = $clog2(RX_W + 1);
   localparam int TO_W = (TX_TIMEOUT > 0) ? $clog2(TX_TIMEOUT + 1) : 1;
   localparam logic [BC_W-1:0] C_BC_LAST = BC_W'(RX_W - 1);
   localparam logic [TO_W-1:0] C_TO_LAST = TO_W'((TX_TIMEOUT > 0) ? TX_TIMEOUT - 1 : 0);
   localparam logic [TO_W-1:0] C_TO_MAX  = TO_W'(TX_TIMEOUT);

   state_t          r_state, w_state_nxt;
   logic [RX_W-1:0] r_shift, w_shift_nxt;
   logic [RX_W-1:0] r_rx_data, w_rx_data_nxt;
   logic [BC_W-1:0] r_bit_cnt, w_bit_cnt_nxt;
   logic [TO_W-1:0] r_to_cnt, w_to_cnt_nxt;
   logic            r_rx_valid, w_rx_valid_nxt;
   logic            r_frame_err, w_frame_err_nxt;
   logic            r_held, w_held_nxt;
   logic            w_load, w_clear;
   logic [RX_W-1:0] w_word;
   logic [1:0]      w_cmd;
   logic            w_match;
   logic            w_tx_done;

   assign w_word = {r_shift[RX_W-2:0], mosi};
   assign w_cmd  = w_word[RX_W-1:RX_W-2];

   // State and datapath registers; async reset returns everything to idle
   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         r_state     <= ST_IDLE;
         r_shift     <= '0;
         r_rx_data   <= '0;
         r_bit_cnt   <= '0;
         r_to_cnt    <= '0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_held      <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_shift     <= w_shift_nxt;
         r_rx_data   <= w_rx_data_nxt;
         r_bit_cnt   <= w_bit_cnt_nxt;
         r_to_cnt    <= w_to_cnt_nxt;
         r_rx_valid  <= w_rx_valid_nxt;
         r_frame_err <= w_frame_err_nxt;
         r_held      <= w_held_nxt;
      end
   end

   // Next-state and output decode; ss_n high mid-frame always wins
   always_comb begin
      w_state_nxt     = r_state;
      w_shift_nxt     = r_shift;
      w_rx_data_nxt   = r_rx_data;
      w_bit_cnt_nxt   = r_bit_cnt;
      w_to_cnt_nxt    = r_to_cnt;
      w_rx_valid_nxt  = 1'b0;
      w_frame_err_nxt = 1'b0;
      w_held_nxt      = r_held;
      w_load          = 1'b0;
      w_clear         = 1'b0;
      w_match         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            w_bit_cnt_nxt = '0;
            if (!ss_n) w_state_nxt = ST_CHK_CMD;
         end
         ST_CHK_CMD: begin
            w_bit_cnt_nxt = '0;
            if (ss_n)        w_state_nxt = ST_IDLE;
            else if (!mosi)  w_state_nxt = ST_WRITE;
            else if (r_held) w_state_nxt = ST_READ_DATA;
            else             w_state_nxt = ST_READ_ADD;
         end
         ST_WRITE, ST_READ_ADD, ST_READ_DATA: begin
            if (ss_n) begin
               w_state_nxt     = ST_IDLE;
               w_frame_err_nxt = 1'b1;
            end else begin
               w_shift_nxt = w_word;
               if (r_bit_cnt == C_BC_LAST) begin
                  case (r_state)
                     ST_WRITE:    w_match = (w_cmd == CMD_WR_ADDR) || (w_cmd == CMD_WR_DATA);
                     ST_READ_ADD: w_match = (w_cmd == CMD_RD_ADDR);
                     default:     w_match = (w_cmd == CMD_RD_DATA);
                  endcase
                  if (w_match) begin
                     w_rx_data_nxt  = w_word;
                     w_rx_valid_nxt = 1'b1;
                     if (r_state == ST_READ_DATA) begin
                        w_state_nxt  = ST_WAIT_TX;
                        w_to_cnt_nxt = '0;
                     end else begin
                        w_state_nxt = ST_DONE;
                        if (r_state == ST_READ_ADD) w_held_nxt = 1'b1;
                     end
                  end else begin
                     w_frame_err_nxt = 1'b1;
                     w_state_nxt     = ST_DONE;
                  end
               end else begin
                  w_bit_cnt_nxt = r_bit_cnt + 1'b1;
               end
            end
         end
         ST_WAIT_TX: begin
            if (ss_n) begin
               w_state_nxt     = ST_IDLE;
               w_frame_err_nxt = 1'b1;
            end else if (tx_valid) begin
               w_load      = 1'b1;
               w_state_nxt = ST_TX;
            end else if ((TX_TIMEOUT != 0) && (r_to_cnt == C_TO_LAST)) begin
               w_frame_err_nxt = 1'b1;
               w_held_nxt      = 1'b0;
               w_state_nxt     = ST_DONE;
            end else if (r_to_cnt != C_TO_MAX) begin
               w_to_cnt_nxt = r_to_cnt + 1'b1;
            end
         end
         ST_TX: begin
            if (ss_n) begin
               w_state_nxt     = ST_IDLE;
               w_frame_err_nxt = 1'b1;
               w_clear         = 1'b1;
            end else if (w_tx_done) begin
               w_state_nxt = ST_DONE;
               w_held_nxt  = 1'b0;
            end
         end
         ST_DONE: begin
            if (ss_n) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   spi_tx_serializer #(
      .PAYLOAD_W (PAYLOAD_W)
   ) u_tx_ser (
      .clk   (clk),
      .arst  (arst),
      .load  (w_load),
      .clear (w_clear),
      .data  (tx_data),
      .miso  (miso),
      .done  (w_tx_done)
   );

   assign rx_data      = r_rx_data;
   assign rx_valid     = r_rx_valid;
   assign frame_err    = r_frame_err;
   assign rd_addr_held = r_held;
   assign busy         = (r_state != ST_IDLE);

endmodule
`default_nettype wire
